// File: rtl/fir_pkg.sv
// Shared definitions for the 16-bit FIR filter chain.
// Holds the common sample width and an elaboration-time log2 helper.
package fir_pkg;

    localparam int SAMPLE_W = 16;

    // Ceiling log2; clog2(1) is 0, so callers needing a 1-bit minimum must clamp.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count and valid flag.
// A write is accepted while full only when a read happens in the same cycle.
module sync_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_wr,
    input  logic [WIDTH-1:0]            i_wr_data,
    input  logic                        i_rd,
    output logic [WIDTH-1:0]            o_rd_data,
    output logic [clog2(DEPTH+1)-1:0]   o_count,
    output logic                        o_full,
    output logic                        o_valid
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;

    logic             w_do_rd;
    logic             w_do_wr;
    logic [CNT_W-1:0] w_count_next;

    assign o_full  = (r_count == CNT_FULL);
    assign w_do_rd = i_rd && r_valid;
    assign w_do_wr = i_wr && (!o_full || w_do_rd);

    always_comb begin
        // NOTE: default assigned first so every path drives w_count_next and no latch is inferred.
        w_count_next = r_count;
        case ({w_do_wr, w_do_rd})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_valid <= (w_count_next != '0);
        end
    end

    // NOTE: storage is deliberately not reset; reset pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_valid   = r_valid;

endmodule

// File: rtl/fir_decimator.sv
// Keeps one FIR output sample in every DECIM enabled samples and buffers it in a FIFO.
// A sticky overflow flag records kept samples dropped because the FIFO was full.
module fir_decimator
    import fir_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DECIM = 4,
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            din,
    input  logic                        din_en,
    output logic [WIDTH-1:0]            dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic [clog2(DEPTH+1)-1:0]   count,
    output logic                        overflow,
    input  logic                        clear_ovf
);

    // DECIM=1 still needs a 1-bit phase register; it simply stays at 0.
    localparam int PH_W = (DECIM > 1) ? clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

    logic [PH_W-1:0]  r_phase;
    logic             r_overflow;

    logic             w_keep;
    logic             w_rd;
    logic             w_drop;
    logic             w_full;
    logic             w_valid;
    logic [WIDTH-1:0] w_rd_data;

    assign w_keep = din_en && (r_phase == '0);
    assign w_rd   = w_valid && dout_ready;
    assign w_drop = w_keep && w_full && !w_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= '0;
        end else if (din_en) begin
            r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
        end
    end

    // A drop in the same cycle as clear_ovf leaves the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr      (w_keep && !w_drop),
        .i_wr_data (din),
        .i_rd      (w_rd),
        .o_rd_data (w_rd_data),
        .o_count   (count),
        .o_full    (w_full),
        .o_valid   (w_valid)
    );

    assign dout_valid = w_valid;
    assign dout       = w_valid ? w_rd_data : '0;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_fir_decimator.sv
// Scoreboard bench for fir_decimator with DECIM=4, 1 and 2 instances sharing stimulus.
module tb_fir_decimator;

    localparam int DEPTH = 8;

    logic        clk;
    logic        reset;
    logic [15:0] din;
    logic        din_en;
    logic        dout_ready;
    logic        clear_ovf;

    logic [15:0] dout   [3];
    logic        dvalid [3];
    logic [3:0]  cnt    [3];
    logic        ovf    [3];

    fir_decimator #(.WIDTH(16), .DECIM(4), .DEPTH(DEPTH)) u_d4 (
        .clk(clk), .reset(reset), .din(din), .din_en(din_en),
        .dout(dout[0]), .dout_valid(dvalid[0]), .dout_ready(dout_ready),
        .count(cnt[0]), .overflow(ovf[0]), .clear_ovf(clear_ovf)
    );
    fir_decimator #(.WIDTH(16), .DECIM(1), .DEPTH(DEPTH)) u_d1 (
        .clk(clk), .reset(reset), .din(din), .din_en(din_en),
        .dout(dout[1]), .dout_valid(dvalid[1]), .dout_ready(dout_ready),
        .count(cnt[1]), .overflow(ovf[1]), .clear_ovf(clear_ovf)
    );
    fir_decimator #(.WIDTH(16), .DECIM(2), .DEPTH(DEPTH)) u_d2 (
        .clk(clk), .reset(reset), .din(din), .din_en(din_en),
        .dout(dout[2]), .dout_valid(dvalid[2]), .dout_ready(dout_ready),
        .count(cnt[2]), .overflow(ovf[2]), .clear_ovf(clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_bad;
    int          sel;
    int          m_decim;
    int          m_phase;
    logic        m_ovf;
    logic [15:0] sb[$];
    logic [15:0] popped[$];

    logic [15:0] obs_dout;
    logic        obs_valid;
    logic [3:0]  obs_count;
    logic        obs_ovf;

    always_comb begin
        obs_dout  = dout[sel];
        obs_valid = dvalid[sel];
        obs_count = cnt[sel];
        obs_ovf   = ovf[sel];
    end

    // One clock of stimulus: reads are checked against the scoreboard head before the
    // edge, and the registered state is checked against the model on the next falling edge.
    task automatic step(input logic en, input logic [15:0] d, input logic rdy, input logic clr);
        logic        drop;
        logic [15:0] exp_dout;
        din_en     = en;
        din        = d;
        dout_ready = rdy;
        clear_ovf  = clr;
        #1;
        if (sb.size() > 0 && rdy) begin
            n_cmp++;
            if (obs_dout !== sb[0]) begin
                n_bad++;
                $display("FAIL read_data: got %0d expected %0d", obs_dout, sb[0]);
            end
            popped.push_back(obs_dout);
            void'(sb.pop_front());
        end
        drop = 1'b0;
        if (en && m_phase == 0) begin
            if (sb.size() < DEPTH) sb.push_back(d);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (en) m_phase = (m_phase == m_decim - 1) ? 0 : m_phase + 1;
        @(posedge clk);
        @(negedge clk);
        exp_dout = (sb.size() > 0) ? sb[0] : 16'd0;
        n_cmp += 4;
        if (obs_count !== 4'(sb.size())) begin
            n_bad++;
            $display("FAIL count: got %0d expected %0d", obs_count, sb.size());
        end
        if (obs_valid !== (sb.size() > 0)) begin
            n_bad++;
            $display("FAIL dout_valid: got %0b expected %0b", obs_valid, sb.size() > 0);
        end
        if (obs_dout !== exp_dout) begin
            n_bad++;
            $display("FAIL dout_head: got %0d expected %0d", obs_dout, exp_dout);
        end
        if (obs_ovf !== m_ovf) begin
            n_bad++;
            $display("FAIL overflow: got %0b expected %0b", obs_ovf, m_ovf);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        din_en     = 1'b0;
        din        = 16'd0;
        dout_ready = 1'b0;
        clear_ovf  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        sb.delete();
        popped.delete();
        m_phase = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (dvalid[k] !== 1'b0 || dout[k] !== 16'd0 || cnt[k] !== 4'd0 || ovf[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state[%0d]: got v=%0b d=%0d c=%0d o=%0b required all 0",
                         k, dvalid[k], dout[k], cnt[k], ovf[k]);
            end
        end
    endtask

    task automatic test_decim4();
        int max_cnt;
        do_reset();
        sel = 0; m_decim = 4; max_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 16'(i + 1), 1'b1, 1'b0);
            if (i == 0) begin
                n_cmp++;
                if (obs_valid !== 1'b1 || obs_dout !== 16'd1) begin
                    n_bad++;
                    $display("FAIL first_keep: got v=%0b d=%0d required v=1 d=1", obs_valid, obs_dout);
                end
            end
            if (int'(obs_count) > max_cnt) max_cnt = int'(obs_count);
        end
        n_cmp++;
        if (max_cnt > 1) begin
            n_bad++;
            $display("FAIL decim4_max_count: got %0d required <=1", max_cnt);
        end
        n_cmp++;
        if (popped.size() != 4) begin
            n_bad++;
            $display("FAIL decim4_n_out: got %0d required 4", popped.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (popped[k] !== 16'(1 + 4 * k)) begin
                    n_bad++;
                    $display("FAIL decim4_seq[%0d]: got %0d required %0d", k, popped[k], 1 + 4 * k);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        sel = 1; m_decim = 1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'(10 + i), 1'b0, 1'b0);
            if (i == 7) begin
                n_cmp++;
                if (obs_count !== 4'd8 || obs_ovf !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_full: got c=%0d o=%0b required c=8 o=0", obs_count, obs_ovf);
                end
            end
            if (i == 8) begin
                n_cmp++;
                if (obs_ovf !== 1'b1) begin
                    n_bad++;
                    $display("FAIL bp_ovf_on_18: got %0b required 1", obs_ovf);
                end
            end
        end
        popped.delete();
        for (int i = 0; i < 8; i++) step(1'b0, 16'd0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (k >= popped.size() || popped[k] !== 16'(10 + k)) begin
                n_bad++;
                $display("FAIL bp_drain[%0d]: got %0d required %0d", k,
                         (k < popped.size()) ? popped[k] : 16'hxxxx, 10 + k);
            end
        end
        n_cmp++;
        if (obs_ovf !== 1'b1 || obs_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_sticky: got o=%0b v=%0b required o=1 v=0", obs_ovf, obs_valid);
        end
        step(1'b0, 16'd0, 1'b0, 1'b1);
        n_cmp++;
        if (obs_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_clear: got %0b required 0", obs_ovf);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        sel = 1; m_decim = 1;
        for (int i = 0; i < 8; i++) step(1'b1, 16'(200 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'(300 + i), 1'b1, 1'b0);
            n_cmp++;
            if (obs_count !== 4'd8 || obs_ovf !== 1'b0) begin
                n_bad++;
                $display("FAIL full_rd_wr[%0d]: got c=%0d o=%0b required c=8 o=0", i, obs_count, obs_ovf);
            end
        end
        for (int i = 0; i < 9; i++) step(1'b0, 16'd0, 1'b1, 1'b0);
    endtask

    task automatic test_gaps();
        logic [15:0] exp_gap[3];
        exp_gap[0] = 16'd100; exp_gap[1] = 16'd104; exp_gap[2] = 16'd108;
        do_reset();
        sel = 2; m_decim = 2;
        for (int c = 0; c < 12; c++) step((c % 2) == 0, 16'(100 + c), 1'b1, 1'b0);
        step(1'b0, 16'd0, 1'b1, 1'b0);
        n_cmp++;
        if (popped.size() != 3) begin
            n_bad++;
            $display("FAIL gaps_n_out: got %0d required 3", popped.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (popped[k] !== exp_gap[k]) begin
                    n_bad++;
                    $display("FAIL gaps_seq[%0d]: got %0d required %0d", k, popped[k], exp_gap[k]);
                end
            end
        end
    endtask

    task automatic test_clear_vs_drop();
        do_reset();
        sel = 1; m_decim = 1;
        for (int i = 0; i < 8; i++) step(1'b1, 16'(400 + i), 1'b0, 1'b0);
        step(1'b1, 16'h0055, 1'b0, 1'b1);
        n_cmp++;
        if (obs_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL set_beats_clear: got %0b required 1", obs_ovf);
        end
        step(1'b0, 16'd0, 1'b0, 1'b1);
        n_cmp++;
        if (obs_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_after_drop: got %0b required 0", obs_ovf);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sel = 1; m_decim = 1;
        for (int i = 0; i < 5; i++) step(1'b1, 16'(500 + i), 1'b0, 1'b0);
        n_cmp++;
        if (obs_count !== 4'd5) begin
            n_bad++;
            $display("FAIL mid_count: got %0d required 5", obs_count);
        end
        do_reset();
        n_cmp++;
        if (obs_count !== 4'd0 || obs_valid !== 1'b0 || obs_dout !== 16'd0 || obs_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: got c=%0d v=%0b d=%0d o=%0b required all 0",
                     obs_count, obs_valid, obs_dout, obs_ovf);
        end
        sel = 0; m_decim = 4;
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        n_cmp++;
        if (obs_valid !== 1'b1 || obs_dout !== 16'h1234) begin
            n_bad++;
            $display("FAIL post_reset_keep: got v=%0b d=%0h required v=1 d=1234", obs_valid, obs_dout);
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; sel = 0; m_decim = 4;
        reset = 1'b1; din = 16'd0; din_en = 1'b0; dout_ready = 1'b0; clear_ovf = 1'b0;
        @(negedge clk);
        test_reset();
        test_decim4();
        test_backpressure();
        test_back_to_back();
        test_gaps();
        test_clear_vs_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_decimator.md
# fir_decimator

Downstream stage of the 16-bit FIR filter. It takes the filter output sample stream (one sample per enabled clock), keeps one sample in every DECIM, and buffers the kept samples in a small FIFO. Consumers drain the FIFO through a valid/ready handshake. A sticky flag reports samples lost because the buffer was full.

## Interface
Parameters:
- WIDTH, 16: sample width; must equal the FIR output width.
- DECIM, 4: decimation ratio, ≥1; DECIM=1 passes every sample.
- DEPTH, 8: FIFO depth in samples; power of two, ≥2.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high; sampled on the rising edge of clk.
- din, input, WIDTH: FIR output sample (connects to the filter's y).
- din_en, input, 1: din holds a new sample this cycle. Tie high when the FIR runs every clock.
- dout, output, WIDTH: head-of-FIFO sample; 0 when the FIFO is empty.
- dout_valid, output, 1: FIFO not empty.
- dout_ready, input, 1: consumer accepts dout this cycle.
- count, output, $clog2(DEPTH+1): number of samples held.
- overflow, output, 1: sticky; a kept sample was dropped because the FIFO was full.
- clear_ovf, input, 1: clears overflow.

## Operation
- Phase counter, range 0..DECIM-1, resets to 0. It advances by one on each din_en cycle and wraps from DECIM-1 to 0.
- Keep: din is kept when din_en=1 and phase=0. The first enabled sample after reset is therefore kept, followed by every DECIM-th enabled sample.
- Read: rd = dout_valid && dout_ready. The pop pointer advances and count decrements.
- Write: wr = keep && (count<DEPTH || rd). The write pointer advances and count increments.
  - When the FIFO is full and a read happens in the same cycle, the kept sample is still written.
- Drop: keep && count==DEPTH && !rd. The sample is discarded and overflow is set.
- Simultaneous wr and rd: count is unchanged and both pointers advance.
- Empty: dout_valid=0 and dout=0. dout_ready is ignored.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- overflow:
  - Set by a drop event, cleared by clear_ovf.
  - When set and clear occur in the same cycle, set wins.
- din_en=0: phase holds and nothing is written. Reads continue normally.
- Data passes through unmodified, with no arithmetic on samples.
- Reset:
  - Clears phase, both pointers, count and overflow, so all outputs reset to 0.
  - FIFO storage is not reset.
  - Reset mid-operation discards all buffered samples and restarts phase at 0.
  - Reset takes priority over every other input in that cycle.

## Timing
- Keep-to-output latency is 1 cycle. A sample kept at edge N is visible on dout/dout_valid after edge N, provided the FIFO was empty.
- dout is a combinational read of the storage at the pop pointer, masked by dout_valid. There is no extra output register.
- A handshake completes at the edge where dout_valid && dout_ready. The next entry, or 0 if the FIFO is now empty, appears after that edge.
- count, dout_valid and overflow are registered and update at the same edge as the pointers.
- Throughput:
  - The block accepts one kept sample per cycle while ready is held high.
  - With a continuous stream and DECIM=1, the FIFO never fills as long as dout_ready stays high.

## Structure
- Shared package fir_pkg:
  - SAMPLE_W=16, the common sample width for the FIR chain.
  - A clog2 constant function.
- Sub-module sync_fifo, parameterised by WIDTH and DEPTH. It holds the storage, pointers, count and full/empty logic, and its rd/wr ports have the same-cycle rules above.
- fir_decimator itself holds the phase counter, keep/drop logic, the overflow flag and output masking.

## Test plan
- Reset, DECIM=4, din_en=1, din=1,2,3,…, dout_ready=1: dout_valid rises after the edge that keeps 1. dout sequence is 1,5,9,13. count never exceeds 1.
- Backpressure, dout_ready=0, DEPTH=8, DECIM=1, din=10..19: count reaches 8 after 8 cycles and overflow sets on sample 18. Draining afterwards yields 10..17 in order, and overflow stays 1 until clear_ovf pulses.
- Full FIFO with simultaneous read and keep: count stays 8, no drop occurs, and overflow stays 0.
- Gaps, din_en toggling 1,0,1,0 with DECIM=2 and din=100+cycle: only samples on enabled cycles count toward the phase. Kept samples are enabled samples 1, 3, 5, ….
- Same-cycle clear_ovf and drop event: overflow remains 1.
- Reset asserted with count=5: the next cycle shows count=0, dout_valid=0, dout=0 and overflow=0. The first enabled sample after reset is kept.
